// File: rtl/sdr_stream_reader.sv
// Splits one (base, nwords) job into avalon_sdr chunk reads of at most MAX_NREAD words and
// streams the words out over valid/ready, prefetching the next chunk while the current one drains.
module sdr_stream_reader #(
  parameter int unsigned MAX_NREAD = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [29:0]             nwords,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    out_last,
  output logic [31:0]             sdr_baseaddr,
  output logic [29:0]             sdr_nelems,
  output logic                    sdr_readstart,
  input  logic                    sdr_readend,
  input  logic [32*MAX_NREAD-1:0] sdr_readdata
);

  localparam int unsigned IDX_W = (MAX_NREAD > 1) ? $clog2(MAX_NREAD) : 1;
  localparam int unsigned LEN_W = $clog2(MAX_NREAD + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, FETCH, HOLD, DRAIN} state_t;

  state_t           state;
  logic [31:0]      addr;
  logic [29:0]      rem;
  logic [29:0]      words_left;
  logic [LEN_W-1:0] chunk;
  logic [LEN_W-1:0] buf_len;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      buf_mem [MAX_NREAD];
  logic [31:0]      rd_words_c [MAX_NREAD];

  logic             hs_c;
  logic             last_word_c;
  logic             bfree_c;
  logic             load_c;
  logic [LEN_W-1:0] chunk_next_c;

  for (genvar g = 0; g < MAX_NREAD; g++) begin : g_unpack
    assign rd_words_c[g] = sdr_readdata[32*g +: 32];
  end

  assign hs_c         = out_valid & out_ready;
  assign last_word_c  = (LEN_W'(rd_idx) == (buf_len - LEN_W'(1)));
  // Buffer can take a new chunk if empty or its final word leaves this cycle
  assign bfree_c      = (buf_len == '0) | (hs_c & last_word_c);
  assign load_c       = ((state == FETCH) & sdr_readend & bfree_c) | ((state == HOLD) & bfree_c);
  assign chunk_next_c = (rem > 30'(MAX_NREAD)) ? LEN_W'(MAX_NREAD) : LEN_W'(rem);

  assign out_valid = (buf_len != '0);
  assign out_data  = buf_mem[rd_idx];
  assign out_last  = out_valid & (words_left == 30'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      sdr_readstart <= 1'b0;
      sdr_baseaddr  <= '0;
      sdr_nelems    <= '0;
      addr          <= '0;
      rem           <= '0;
      words_left    <= '0;
      chunk         <= '0;
      buf_len       <= '0;
      rd_idx        <= '0;
      buf_mem       <= '{default: '0};
    end else begin
      done          <= 1'b0;
      sdr_readstart <= 1'b0;

      // Output side; a same-cycle load overrides the pointer/length update
      if (hs_c) begin
        rd_idx     <= rd_idx + IDX_W'(1);
        words_left <= words_left - 30'd1;
        if (last_word_c) buf_len <= '0;
      end
      if (load_c) begin
        buf_mem <= rd_words_c;
        buf_len <= chunk;
        rd_idx  <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (nwords == 30'd0) begin
              done <= 1'b1;
            end else begin
              addr       <= base_addr;
              rem        <= nwords;
              words_left <= nwords;
              busy       <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          sdr_baseaddr  <= addr;
          sdr_nelems    <= 30'(chunk_next_c);
          chunk         <= chunk_next_c;
          addr          <= addr + (32'(chunk_next_c) << 2);
          rem           <= rem - 30'(chunk_next_c);
          sdr_readstart <= 1'b1;
          state         <= FETCH;
        end
        FETCH: begin
          if (sdr_readend) begin
            if (!bfree_c)            state <= HOLD;
            else if (rem != 30'd0)   state <= ISSUE;
            else                     state <= DRAIN;
          end
        end
        HOLD: begin
          if (bfree_c) state <= (rem != 30'd0) ? ISSUE : DRAIN;
        end
        DRAIN: begin
          if (hs_c & out_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_stream_reader.sv
// Directed bench for sdr_stream_reader: job table plus reset-abort sequence, against a
// behavioural avalon_sdr responder and an output-stream monitor.
module tb_sdr_stream_reader;

  localparam int unsigned MAXN = 64;
  localparam int unsigned LAT  = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [31:0]         base_addr = '0;
  logic [29:0]         nwords = '0;
  logic                busy, done, out_valid, out_last, sdr_readstart;
  logic                out_ready = 1'b0;
  logic [31:0]         out_data, sdr_baseaddr;
  logic [29:0]         sdr_nelems;
  logic                sdr_readend;
  logic [32*MAXN-1:0]  sdr_readdata;

  always #5 clk = ~clk;

  sdr_stream_reader #(.MAX_NREAD(MAXN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .nwords(nwords),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .sdr_baseaddr(sdr_baseaddr),
    .sdr_nelems(sdr_nelems), .sdr_readstart(sdr_readstart), .sdr_readend(sdr_readend),
    .sdr_readdata(sdr_readdata)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_F00D;
  endfunction

  function automatic logic [32*MAXN-1:0] chunk_data(input logic [31:0] a, input int n);
    logic [32*MAXN-1:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[32*i +: 32] = word_of(a + 32'(4 * i));
    return d;
  endfunction

  // Bookkeeping shared by responder, monitor and job task
  int          cyc = 0;
  int          rx_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          last_hs_cyc = -1;
  bit          valid_seen = 1'b0;
  logic [31:0] rx_data_q[$];
  logic        rx_last_q[$];
  logic [31:0] req_addr_q[$];
  int          req_n_q[$];
  int          req_rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // avalon_sdr responder: fixed latency, readdata held until the next completion
  logic        pend;
  int          lat_cnt;
  logic [31:0] m_addr;
  logic [29:0] m_n;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend         <= 1'b0;
      lat_cnt      <= 0;
      m_addr       <= '0;
      m_n          <= '0;
      sdr_readend  <= 1'b0;
      sdr_readdata <= '0;
    end else begin
      sdr_readend <= 1'b0;
      if (sdr_readstart) begin
        pend    <= 1'b1;
        lat_cnt <= LAT;
        m_addr  <= sdr_baseaddr;
        m_n     <= sdr_nelems;
        req_addr_q.push_back(sdr_baseaddr);
        req_n_q.push_back(int'(sdr_nelems));
        req_rx_q.push_back(rx_cnt);
        chk("nelems_range", 32'(sdr_nelems >= 30'd1 && sdr_nelems <= 30'(MAXN)), 32'd1);
      end else if (pend) begin
        if (lat_cnt == 0) begin
          pend         <= 1'b0;
          sdr_readend  <= 1'b1;
          sdr_readdata <= chunk_data(m_addr, int'(m_n));
          chk("baseaddr_stable", sdr_baseaddr, m_addr);
          chk("nelems_stable", 32'(sdr_nelems), 32'(m_n));
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) valid_seen = 1'b1;
      if (stall_prev && out_valid) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        rx_data_q.push_back(out_data);
        rx_last_q.push_back(out_last);
        rx_cnt++;
        if (out_last) last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Consumer: 0 always ready, 1 stall for 200 valid cycles, 2 random
  int ready_mode = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          if (out_valid) stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  typedef struct {
    logic [31:0] base;
    int          n;
    int          mode;
    int          exp_nreq;
    int          overlap;   // 1: 2nd request before chunk 1 drained, 2: 3rd request only after
    bit          intrude;
  } job_t;

  job_t jobs[8];

  task automatic clear_logs();
    rx_data_q.delete();
    rx_last_q.delete();
    req_addr_q.delete();
    req_n_q.delete();
    req_rx_q.delete();
    rx_cnt      = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    last_hs_cyc = -1;
    valid_seen  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_readstart"}, 32'(sdr_readstart), 32'd0);
    chk({tag, "_baseaddr"}, sdr_baseaddr, 32'd0);
    chk({tag, "_nelems"}, 32'(sdr_nelems), 32'd0);
  endtask

  task automatic run_job(input int idx, input job_t j);
    logic [31:0] a;
    int          r, c, k, ncmp;
    string       p;
    p = $sformatf("job%0d", idx);
    clear_logs();
    ready_mode = j.mode;
    stall_left = 200;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = j.base;
    nwords    = 30'(j.n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({p, "_busy_after_start"}, 32'(busy), (j.n != 0) ? 32'd1 : 32'd0);
    if (j.intrude) begin
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 32'h0000_5000;
      nwords    = 30'd20;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int t = 0; t < 4000; t++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    chk({p, "_done_timeout"}, 32'(done_cnt != 0), 32'd1);
    repeat (8) @(negedge clk);

    chk({p, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({p, "_busy_end"}, 32'(busy), 32'd0);
    chk({p, "_word_count"}, 32'(rx_data_q.size()), 32'(j.n));
    chk({p, "_valid_seen"}, 32'(valid_seen), (j.n != 0) ? 32'd1 : 32'd0);
    ncmp = (rx_data_q.size() < j.n) ? rx_data_q.size() : j.n;
    for (int i = 0; i < ncmp; i++) begin
      chk($sformatf("%s_data%0d", p, i), rx_data_q[i], word_of(j.base + 32'(4 * i)));
      chk($sformatf("%s_last%0d", p, i), 32'(rx_last_q[i]), 32'(i == j.n - 1));
    end
    if (j.n != 0) chk({p, "_done_latency"}, 32'(done_cyc), 32'(last_hs_cyc + 1));

    chk({p, "_nreq"}, 32'(req_addr_q.size()), 32'(j.exp_nreq));
    a = j.base;
    r = j.n;
    k = 0;
    while (r > 0) begin
      c = (r > MAXN) ? MAXN : r;
      if (k < req_addr_q.size()) begin
        chk($sformatf("%s_req%0d_addr", p, k), req_addr_q[k], a);
        chk($sformatf("%s_req%0d_n", p, k), 32'(req_n_q[k]), 32'(c));
      end
      a = a + 32'(4 * c);
      r = r - c;
      k++;
    end
    if (j.overlap == 1 && req_rx_q.size() > 1)
      chk({p, "_prefetch_overlap"}, 32'(req_rx_q[1] < MAXN), 32'd1);
    if (j.overlap == 2 && req_rx_q.size() > 2)
      chk({p, "_hold_no_early_req"}, 32'(req_rx_q[2] >= MAXN), 32'd1);
    ready_mode = 0;
  endtask

  initial begin
    jobs[0] = '{32'h0000_1000,   3, 0, 1, 0, 1'b0};
    jobs[1] = '{32'h0000_1000, 130, 0, 3, 1, 1'b0};
    jobs[2] = '{32'h0000_1000, 130, 1, 3, 2, 1'b0};
    jobs[3] = '{32'h0000_2000,   0, 0, 0, 0, 1'b0};
    jobs[4] = '{32'h0000_3000,  10, 0, 1, 0, 1'b1};
    jobs[5] = '{32'h0000_2000,  64, 2, 1, 0, 1'b0};
    jobs[6] = '{32'h0000_0000,  65, 2, 2, 0, 1'b0};
    jobs[7] = '{32'hFFFF_FF00,  70, 0, 2, 0, 1'b0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(i, jobs[i]);

    // Abort in the middle of the second chunk fetch
    clear_logs();
    ready_mode = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 32'h0000_1000;
    nwords    = 30'd130;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (req_addr_q.size() >= 2) break;
      @(negedge clk);
    end
    chk("abort_second_request_seen", 32'(req_addr_q.size() >= 2), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_zero("abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_job(8, '{32'h0000_4000, 5, 0, 1, 0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
